// File: rtl/adiabatic_phase_ctrl.sv
// Four-domain adiabatic power-clock generator: trapezoidal ramps offset by a quarter period.
// Optional stall input enabled by defining ADIABATIC_PHASE_CTRL_STALL_EN.

module adiabatic_phase_lane #(
    parameter int STEPS = 8,
    parameter int LW    = 4,
    parameter int SW    = 3,
    parameter int D     = 0
) (
    input  logic [SW-1:0] s,
    input  logic [1:0]    q,
    input  logic          en,
    input  logic          in_run,
    input  logic          in_drain,
    output logic          en_eff,
    output logic [LW-1:0] level,
    output logic [1:0]    phase
);
    logic [1:0] lq;

    assign lq = q - 2'(D);

    // Enabling only at the start of RISE and disabling only in WAIT keeps level steps <= 1.
    always_comb begin
        en_eff = en;
        if (in_run && lq == 2'd0 && s == '0)
            en_eff = 1'b1;
        if (in_drain && lq == 2'd3)
            en_eff = 1'b0;
    end

    always_comb begin
        phase = 2'd3;
        level = '0;
        if (en_eff) begin
            phase = lq;
            case (lq)
                2'd0:    level = LW'(s) + LW'(1);
                2'd1:    level = LW'(STEPS);
                2'd2:    level = LW'(STEPS - 1) - LW'(s);
                default: level = '0;
            endcase
        end
    end
endmodule

module adiabatic_phase_ctrl #(
    parameter int STEPS = 8,
    parameter int LW    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
`ifdef ADIABATIC_PHASE_CTRL_STALL_EN
    input  logic            stall,
`endif
    output logic [4*LW-1:0] pc_level,
    output logic [7:0]      pc_phase,
    output logic            busy,
    output logic            quarter_tick,
    output logic [15:0]     period_cnt
);
    localparam int SW = $clog2(STEPS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [SW-1:0] s;
    logic [1:0]    q;
    logic [3:0]    en;
    logic [3:0]    en_eff;
    logic          last_step;
    logic          in_run;
    logic          in_drain;
    logic          frz;

`ifdef ADIABATIC_PHASE_CTRL_STALL_EN
    assign frz = stall;
`else
    assign frz = 1'b0;
`endif

    assign last_step    = (s == SW'(STEPS - 1));
    assign in_run       = (state == RUN);
    assign in_drain     = (state == DRAIN);
    assign busy         = (state != IDLE);
    assign quarter_tick = busy && last_step && !frz;

    for (genvar d = 0; d < 4; d++) begin : g_lane
        adiabatic_phase_lane #(.STEPS(STEPS), .LW(LW), .SW(SW), .D(d)) u_lane (
            .s        (s),
            .q        (q),
            .en       (en[d]),
            .in_run   (in_run),
            .in_drain (in_drain),
            .en_eff   (en_eff[d]),
            .level    (pc_level[d*LW +: LW]),
            .phase    (pc_phase[2*d +: 2])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            s          <= '0;
            q          <= '0;
            en         <= '0;
            period_cnt <= '0;
        end else if (state == IDLE) begin
            s          <= '0;
            q          <= '0;
            en         <= '0;
            period_cnt <= '0;
            if (run)
                state <= RUN;
        end else if (!frz) begin
            en <= en_eff;
            s  <= last_step ? '0 : s + SW'(1);
            if (last_step)
                q <= q + 2'd1;
            if (last_step && q == 2'd3)
                period_cnt <= period_cnt + 16'd1;
            case (state)
                RUN: if (!run) state <= DRAIN;
                DRAIN: begin
                    if (run) begin
                        state <= RUN;
                    end else if (en_eff == 4'd0) begin
                        // Last domain just reached WAIT: back to a clean idle.
                        state      <= IDLE;
                        s          <= '0;
                        q          <= '0;
                        en         <= '0;
                        period_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adiabatic_phase_ctrl.sv
// Bench for adiabatic_phase_ctrl at STEPS=4: vector table, directed drain/rerun/reset cases, random run.
// Stall checks are included when ADIABATIC_PHASE_CTRL_STALL_EN is defined.

module tb_adiabatic_phase_ctrl;
    localparam int S  = 4;
    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        reset, run, stall;
    logic [15:0] pc_level;
    logic [7:0]  pc_phase;
    logic        busy, quarter_tick;
    logic [15:0] period_cnt;

    int nchk = 0;
    int nerr = 0;

    adiabatic_phase_ctrl #(.STEPS(S), .LW(LW)) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
`ifdef ADIABATIC_PHASE_CTRL_STALL_EN
        .stall        (stall),
`endif
        .pc_level     (pc_level),
        .pc_phase     (pc_phase),
        .busy         (busy),
        .quarter_tick (quarter_tick),
        .period_cnt   (period_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: one position counter p over the whole period, per-domain enable flags.
    int mst;           // 0 idle, 1 run, 2 drain
    int p;             // position in period, 0..4S-1
    bit men[4];
    int mcnt;
    bit was_reset;
    int prev_lvl[4];

    function automatic bit m_en(int d);
        int lp = (p - d*S + 4*S) % (4*S);
        bit e = men[d];
        if (mst == 1 && lp == 0) e = 1'b1;
        if (mst == 2 && lp / S == 3) e = 1'b0;
        return e;
    endfunction

    function automatic int m_lvl(int d);
        int lp = (p - d*S + 4*S) % (4*S);
        if (mst == 0 || !m_en(d)) return 0;
        case (lp / S)
            0: return lp % S + 1;
            1: return S;
            2: return S - 1 - lp % S;
            default: return 0;
        endcase
    endfunction

    function automatic int m_phase();
        int v = 0;
        for (int d = 0; d < 4; d++) begin
            int lp = (p - d*S + 4*S) % (4*S);
            int ph = (mst != 0 && m_en(d)) ? lp / S : 3;
            v = v | (ph << (2*d));
        end
        return v;
    endfunction

    task automatic m_edge();
        bit effs[4];
        bit any = 1'b0;
        if (reset) begin
            mst = 0; p = 0; mcnt = 0;
            for (int d = 0; d < 4; d++) men[d] = 1'b0;
        end else if (mst == 0) begin
            if (run) mst = 1;
        end else if (!stall) begin
            for (int d = 0; d < 4; d++) begin
                effs[d] = m_en(d);
                any = any | effs[d];
            end
            for (int d = 0; d < 4; d++) men[d] = effs[d];
            if (p == 4*S - 1) mcnt = (mcnt + 1) & 16'hFFFF;
            p = (p + 1) % (4*S);
            if (mst == 1 && !run) mst = 2;
            else if (mst == 2) begin
                if (run) mst = 1;
                else if (!any) begin
                    mst = 0; p = 0; mcnt = 0;
                    for (int d = 0; d < 4; d++) men[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(string name, int act, int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lvl(int d);
        return int'(pc_level[d*LW +: LW]);
    endfunction

    // One clock: advance model, clock DUT, compare everything after the edge.
    task automatic cyc();
        int el = 0;
        was_reset = reset;
        m_edge();
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) el = el | (m_lvl(d) << (LW*d));
        chk("pc_level", int'(pc_level), el);
        chk("pc_phase", int'(pc_phase), m_phase());
        chk("busy", int'(busy), int'(mst != 0));
        chk("quarter_tick", int'(quarter_tick), int'(mst != 0 && p % S == S - 1 && !stall));
        chk("period_cnt", int'(period_cnt), mcnt);
        for (int d = 0; d < 4; d++) begin
            int dl = lvl(d) - prev_lvl[d];
            if (!was_reset) chk("level_delta", int'(dl <= 1 && dl >= -1), 1);
            prev_lvl[d] = lvl(d);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; stall = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    typedef struct {
        int l0;
        int l1;
        int tk;
        int cnt;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int nfall;
        bit done;
        logic [7:0] prev_ph;

        tbl = '{'{1,0,0,0}, '{2,0,0,0}, '{3,0,0,0}, '{4,0,1,0},
                '{4,1,0,0}, '{4,2,0,0}, '{4,3,0,0}, '{4,4,1,0},
                '{3,4,0,0}, '{2,4,0,0}, '{1,4,0,0}, '{0,4,1,0},
                '{0,3,0,0}, '{0,2,0,0}, '{0,1,0,0}, '{0,0,1,0},
                '{1,0,0,1}, '{2,0,0,1}, '{3,0,0,1}, '{4,0,1,1}};
        for (int d = 0; d < 4; d++) prev_lvl[d] = 0;

        // Reset state
        do_reset();
        chk("rst_level", int'(pc_level), 0);
        chk("rst_phase", int'(pc_phase), 8'hFF);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tick", int'(quarter_tick), 0);
        chk("rst_cnt", int'(period_cnt), 0);

        // Ramp shape, domain offset, tick cadence
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("tbl_l0", lvl(0), tbl[i].l0);
            chk("tbl_l1", lvl(1), tbl[i].l1);
            chk("tbl_tick", int'(quarter_tick), tbl[i].tk);
            chk("tbl_cnt", int'(period_cnt), tbl[i].cnt);
        end
        repeat (13) cyc();
        chk("two_periods", int'(period_cnt), 2);

        // Drop run while domain 0 in HOLD: drain to idle
        do_reset();
        run = 1'b1;
        repeat (5) cyc();
        chk("hold_l0", lvl(0), 4);
        run = 1'b0;
        done = 1'b0; nfall = 0; prev_ph = '0;
        for (int n = 1; n <= 40 && !done; n++) begin
            prev_ph = pc_phase;
            cyc();
            if (!busy) begin done = 1'b1; nfall = n; end
        end
        chk("drain_len", nfall, 13);
        chk("all_wait_before_idle", int'(prev_ph), 8'hFF);
        chk("idle_cnt", int'(period_cnt), 0);

        // Reassert run during drain
        do_reset();
        run = 1'b1;
        repeat (5) cyc();
        run = 1'b0;
        repeat (9) cyc();
        chk("drain_busy", int'(busy), 1);
        chk("drain_l0_off", lvl(0), 0);
        run = 1'b1;
        cyc();
        chk("rerun_busy", int'(busy), 1);
        cyc();
        chk("rerun_l0_wait", lvl(0), 0);
        cyc();
        chk("rerun_l0_rise", lvl(0), 1);
        repeat (7) cyc();
        chk("rerun_l2_pre", lvl(2), 0);
        cyc();
        chk("rerun_l2_rise", lvl(2), 1);
        repeat (3) cyc();
        chk("rerun_l3_pre", lvl(3), 0);
        cyc();
        chk("rerun_l3_rise", lvl(3), 1);

        // Reset mid-rise
        do_reset();
        run = 1'b1;
        repeat (2) cyc();
        chk("midrise_l0", lvl(0), 2);
        reset = 1'b1;
        cyc();
        chk("midrst_level", int'(pc_level), 0);
        chk("midrst_phase", int'(pc_phase), 8'hFF);
        chk("midrst_busy", int'(busy), 0);
        reset = 1'b0;

`ifdef ADIABATIC_PHASE_CTRL_STALL_EN
        // Stall in HOLD freezes outputs, then the ramp resumes without skipping
        do_reset();
        run = 1'b1;
        repeat (5) cyc();
        stall = 1'b1;
        repeat (3) begin
            cyc();
            chk("stall_l0", lvl(0), 4);
            chk("stall_l1", lvl(1), 1);
            chk("stall_tick", int'(quarter_tick), 0);
        end
        stall = 1'b0;
        cyc();
        chk("resume_l1", lvl(1), 2);
`endif

        // Random run/reset/stall against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom % 16 == 0) run = ~run;
            reset = ($urandom % 150 == 0);
`ifdef ADIABATIC_PHASE_CTRL_STALL_EN
            stall = ($urandom % 8 == 0);
`else
            stall = 1'b0;
`endif
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
